// File: rtl/mult_pkg.sv
// Shared definitions for the iterative Booth multiplier: datapath width,
// step count, FSM state encoding and Booth select encodings.
package mult_pkg;

  localparam int MULT_W     = 16;
  localparam int MULT_STEPS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth select is {Q[0], q_1}; 01 adds M, 10 subtracts M, others shift only
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/twos_comp.sv
// 16-bit ripple-carry add/sub unit. With addsub=1 the Y operand is inverted
// and the carry-in is forced high, so sum = X - Y; otherwise sum = X + Y + Cin.
// overflow flags a signed result that does not fit in MULT_W bits.
module twos_comp
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] X,
  input  logic [MULT_W-1:0] Y,
  input  logic              Cin,
  input  logic              addsub,
  output logic [MULT_W-1:0] sum,
  output logic              Cout,
  output logic              overflow
);

  logic [MULT_W-1:0] yEff;
  logic [MULT_W:0]   carry;

  // Ripple chain: one full adder per bit, carry passed upward
  always_comb begin
    sum      = '0;
    carry    = '0;
    yEff     = Y ^ {MULT_W{addsub}};
    carry[0] = Cin | addsub;
    for (int i = 0; i < MULT_W; i++) begin
      sum[i]       = X[i] ^ yEff[i] ^ carry[i];
      carry[i+1]   = (X[i] & yEff[i]) | (carry[i] & (X[i] ^ yEff[i]));
    end
  end

  assign Cout     = carry[MULT_W];
  assign overflow = carry[MULT_W] ^ carry[MULT_W-1];

endmodule

// File: rtl/booth_mult16.sv
// Iterative 16x16 signed radix-2 Booth multiplier with start/busy/done
// handshake. One Booth step per cycle through a shared ripple add/sub unit;
// the 32-bit product is registered when the 16th step completes.
// Optional macro BOOTH_MULT_OVF_FLAG_EN adds a registered ovf16 output that
// flags products which do not fit in a signed 16-bit value.
module booth_mult16
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MULT_W-1:0]     multiplicand,
  input  logic [MULT_W-1:0]     multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [2*MULT_W-1:0]   product
`ifdef BOOTH_MULT_OVF_FLAG_EN
  ,
  output logic                  ovf16
`endif
);

  state_t              state_q, state_d;
  logic [MULT_W-1:0]   acc_q, acc_d;
  logic [MULT_W-1:0]   mplr_q, mplr_d;
  logic                qMinus1_q, qMinus1_d;
  logic [MULT_W-1:0]   mcand_q, mcand_d;
  logic [4:0]          count_q, count_d;
  logic [2*MULT_W-1:0] product_q, product_d;

  logic [1:0]          boothSel;
  logic                doArith;
  logic                addSub;
  logic [MULT_W-1:0]   addSum;
  logic                addOvf;
  logic                coutUnused;
  logic [MULT_W-1:0]   accNext;
  logic                shiftSign;
  logic                lastStep;

  twos_comp u_addsub (
    .X        (acc_q),
    .Y        (mcand_q),
    .Cin      (1'b0),
    .addsub   (addSub),
    .sum      (addSum),
    .Cout     (coutUnused),
    .overflow (addOvf)
  );

  // Booth step datapath: pick add/sub/none and derive the true sign for the
  // arithmetic shift (adder overflow corrects the sign so M = -32768 is exact)
  always_comb begin
    boothSel  = {mplr_q[0], qMinus1_q};
    doArith   = (boothSel == BOOTH_ADD) || (boothSel == BOOTH_SUB);
    addSub    = (boothSel == BOOTH_SUB);
    accNext   = doArith ? addSum : acc_q;
    shiftSign = doArith ? (addSum[MULT_W-1] ^ addOvf) : acc_q[MULT_W-1];
    lastStep  = (state_q == RUN) && (count_q == 5'(MULT_STEPS - 1));
  end

  // Next-state logic for the FSM, operand/shift registers, counter and product
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    qMinus1_d = qMinus1_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d     = '0;
          mplr_d    = multiplier;
          qMinus1_d = 1'b0;
          mcand_d   = multiplicand;
          count_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d     = {shiftSign, accNext[MULT_W-1:1]};
        mplr_d    = {accNext[0], mplr_q[MULT_W-1:1]};
        qMinus1_d = mplr_q[0];
        count_d   = count_q + 5'd1;
        if (lastStep) begin
          state_d   = DONE;
          product_d = {acc_d, mplr_d};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mplr_q    <= '0;
      qMinus1_q <= 1'b0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      qMinus1_q <= qMinus1_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

`ifdef BOOTH_MULT_OVF_FLAG_EN
  logic ovf16_q, ovf16_d;

  // Flag a product whose upper 17 bits are not all equal, refreshed with product
  always_comb begin
    ovf16_d = ovf16_q;
    if (lastStep) begin
      ovf16_d = !((&product_d[2*MULT_W-1:MULT_W-1]) || !(|product_d[2*MULT_W-1:MULT_W-1]));
    end
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf16_q <= 1'b0;
    end else begin
      ovf16_q <= ovf16_d;
    end
  end

  assign ovf16 = ovf16_q;
`endif

endmodule

// File: tb/tb_booth_mult16.sv
// Self-checking bench for booth_mult16: table-driven vectors plus random
// operands through a product scoreboard, and hand-written sequences for
// handshake timing, ignored start during RUN and mid-operation reset.
module tb_booth_mult16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
`ifdef BOOTH_MULT_OVF_FLAG_EN
  logic        ovf16;
`endif

  booth_mult16 dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
`ifdef BOOTH_MULT_OVF_FLAG_EN
    ,
    .ovf16        (ovf16)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] expQ[$];
  int          checks = 0;
  int          failures = 0;
  int          doneCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected product and compares
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      logic [31:0] e;
      doneCount++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done with product 0x%08h expected no pulse", product);
      end else begin
        e = expQ.pop_front();
        checkOutput("product", product, e);
`ifdef BOOTH_MULT_OVF_FLAG_EN
        checkOutput("ovf16", {31'd0, ovf16},
                    {31'd0, !(($signed(e) >= -32768) && ($signed(e) <= 32767))});
`endif
      end
    end
  end

  // Accept one operation, check handshake latency and the post-done state
  task automatic applyStimulus(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    expQ.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_latency", cyc, 32'd16);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
    checkOutput("done_single_pulse", {31'd0, done}, 32'd0);
    checkOutput("product_hold", product, exp);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc;
    int          dc0;
    logic [15:0] rm;
    logic [15:0] rq;
    int          p;

    vecs[0] = '{16'd3,      16'd4,      32'h0000000C};
    vecs[1] = '{16'hFFFF,   16'hFFFF,   32'h00000001};
    vecs[2] = '{16'd32767,  16'h8000,   32'hC0008000};
    vecs[3] = '{16'h8000,   16'h8000,   32'h40000000};
    vecs[4] = '{16'd300,    16'd300,    32'h00015F90};
    vecs[5] = '{16'd0,      16'hFFFB,   32'h00000000};
    vecs[6] = '{16'h8000,   16'd1,      32'hFFFF8000};
    vecs[7] = '{16'hFFF9,   16'd9,      32'hFFFFFFC1};
    vecs[8] = '{16'd1,      16'h8000,   32'hFFFF8000};
    vecs[9] = '{16'd32767,  16'd32767,  32'h3FFF0001};

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_product", product, 32'd0);
`ifdef BOOTH_MULT_OVF_FLAG_EN
    checkOutput("reset_ovf16", {31'd0, ovf16}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].m, vecs[i].q, vecs[i].exp);
    end

    for (int i = 0; i < 6; i++) begin
      rm = 16'($urandom);
      rq = 16'($urandom);
      p  = int'($signed(rm)) * int'($signed(rq));
      applyStimulus(rm, rq, p);
    end

    // Start pulsed at E5 with new operands while RUN must be ignored
    @(negedge clk);
    multiplicand = 16'd100;
    multiplier   = 16'hFFFD;
    start        = 1'b1;
    expQ.push_back(32'hFFFFFED4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 4) begin
        start        = 1'b1;
        multiplicand = 16'd5;
        multiplier   = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("ignored_start_latency", cyc, 32'd16);
    @(posedge clk);
    dc0 = doneCount;
    repeat (25) @(negedge clk);
    checkOutput("ignored_start_no_second_done", doneCount - dc0, 32'd0);
    checkOutput("ignored_start_product", product, 32'hFFFFFED4);

    // Reset sampled at step 8 of an operation aborts it completely
    @(negedge clk);
    multiplicand = 16'd1234;
    multiplier   = 16'd5;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrun_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrun_reset_done", {31'd0, done}, 32'd0);
    checkOutput("midrun_reset_product", product, 32'd0);
`ifdef BOOTH_MULT_OVF_FLAG_EN
    checkOutput("midrun_reset_ovf16", {31'd0, ovf16}, 32'd0);
`endif
    reset = 1'b0;
    applyStimulus(16'd7, 16'hFFFA, 32'hFFFFFFD6);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
